// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states
// and the width of the {hi_we, lo_we, hi, lo} forwarding bus.
package mdu_ctrl_pkg;

    localparam int MDU_BUS_WD = 66;

    localparam logic [2:0] MDU_OP_MULT  = 3'b000;
    localparam logic [2:0] MDU_OP_MULTU = 3'b001;
    localparam logic [2:0] MDU_OP_DIV   = 3'b010;
    localparam logic [2:0] MDU_OP_DIVU  = 3'b011;
    localparam logic [2:0] MDU_OP_MTHI  = 3'b100;
    localparam logic [2:0] MDU_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_RUN,
        ST_DIV_RUN,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit
// per step; done pulses on the step that produces the last bit.
// Ports: clk, rst (async high), clr (abort), load, step,
//        dividend/divisor in, done, quotient/remainder out.
module mdu_div_core #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    // acc = {remainder, dividend bits still to shift in / quotient bits}
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   dvsr;
    logic [CNT_W-1:0] cnt;
    logic [DW:0]     trial;
    logic [DW:0]     diff;

    // Partial remainder can reach 2*divisor-1, so the trial needs DW+1 bits.
    assign trial = acc[2*DW-1:DW-1];
    assign diff  = trial - {1'b0, dvsr};

    assign done      = step && (cnt == CNT_W'(DW - 1));
    assign quotient  = acc[DW-1:0];
    assign remainder = acc[2*DW-1:DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            dvsr <= '0;
            cnt  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            acc  <= {{DW{1'b0}}, dividend};
            dvsr <= divisor;
            cnt  <= '0;
        end else if (step) begin
            if (!diff[DW]) begin
                acc <= {diff[DW-1:0], acc[DW-2:0], 1'b1};
            end else begin
                acc <= {acc[2*DW-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer for the EX stage.
// Ports: clk, rst (async high), flush, start, op, src_a, src_b in;
//        stallreq, busy, hi_we, lo_we, hi_o, lo_o out.
// Build option MDU_FAST_MUL_EN: single-cycle combinational multiply.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    output logic          stallreq,
    output logic          busy,
    output logic          hi_we,
    output logic          lo_we,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    mdu_state_e state, nxt;

    logic          mul_op, div_op, sgn, dz, launch;
    logic [DW-1:0] mag_a, mag_b;

    logic [2*DW-1:0] prod, prod_fix;
    logic            neg_q, neg_r, res_div;

    logic          div_load, div_step, div_done;
    logic [DW-1:0] quo, rem, q_fix, r_fix;
    logic [DW-1:0] res_hi, res_lo;

`ifndef MDU_FAST_MUL_EN
    logic [2*DW-1:0]  mcand;
    logic [DW-1:0]    mplier;
    logic [CNT_W-1:0] cnt;
`endif

    assign mul_op = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    assign div_op = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    // MULT and DIV are the even codes of each pair
    assign sgn    = ~op[0];
    assign dz     = (src_b == '0);
    assign launch = (state == ST_IDLE) && start && !flush;

    assign mag_a = (sgn && src_a[DW-1]) ? -src_a : src_a;
    assign mag_b = (sgn && src_b[DW-1]) ? -src_b : src_b;

    assign div_load = launch && div_op && !dz;
    assign div_step = (state == ST_DIV_RUN) && !flush;

    mdu_div_core #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -quo : quo;
    assign r_fix    = neg_r ? -rem : rem;
    assign res_hi   = res_div ? r_fix : prod_fix[2*DW-1:DW];
    assign res_lo   = res_div ? q_fix : prod_fix[DW-1:0];

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        stallreq = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_o     = '0;
        lo_o     = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        (op == MDU_OP_MTHI): begin
                            hi_we = 1'b1;
                            hi_o  = src_a;
                        end
                        (op == MDU_OP_MTLO): begin
                            lo_we = 1'b1;
                            lo_o  = src_a;
                        end
                        mul_op: begin
                            stallreq = 1'b1;
`ifdef MDU_FAST_MUL_EN
                            nxt = ST_DONE;
`else
                            nxt = ST_MUL_RUN;
`endif
                        end
                        div_op: begin
                            stallreq = 1'b1;
                            nxt = dz ? ST_DONE : ST_DIV_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN: begin
                stallreq = 1'b1;
`ifdef MDU_FAST_MUL_EN
                nxt = ST_DONE;
`else
                if (cnt == CNT_W'(DW - 1)) begin
                    nxt = ST_DONE;
                end
`endif
            end
            ST_DIV_RUN: begin
                stallreq = 1'b1;
                if (div_done) begin
                    nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                hi_o  = res_hi;
                lo_o  = res_lo;
                nxt   = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
        if (flush || rst) begin
            nxt      = ST_IDLE;
            stallreq = 1'b0;
            hi_we    = 1'b0;
            lo_we    = 1'b0;
            hi_o     = '0;
            lo_o     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            res_div <= 1'b0;
`ifndef MDU_FAST_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
`endif
        end else if (launch && mul_op) begin
            neg_q   <= sgn && (src_a[DW-1] ^ src_b[DW-1]);
            neg_r   <= 1'b0;
            res_div <= 1'b0;
`ifdef MDU_FAST_MUL_EN
            prod    <= {{DW{1'b0}}, mag_a} * {{DW{1'b0}}, mag_b};
`else
            prod    <= '0;
            mcand   <= {{DW{1'b0}}, mag_a};
            mplier  <= mag_b;
            cnt     <= '0;
`endif
        end else if (launch && div_op) begin
            if (dz) begin
                // Divide-by-zero result is staged in the product path
                prod    <= {src_a, {DW{1'b1}}};
                neg_q   <= 1'b0;
                neg_r   <= 1'b0;
                res_div <= 1'b0;
            end else begin
                neg_q   <= sgn && (src_a[DW-1] ^ src_b[DW-1]);
                neg_r   <= sgn && src_a[DW-1];
                res_div <= 1'b1;
            end
`ifndef MDU_FAST_MUL_EN
        end else if (flush) begin
            cnt <= '0;
        end else if (state == ST_MUL_RUN) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= {mcand[2*DW-2:0], 1'b0};
            mplier <= {1'b0, mplier[DW-1:1]};
            cnt    <= cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected strobes,
// a negedge monitor pops and compares every HI/LO write it sees.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_STALL = 1;
    localparam logic [2:0] RST_OP = MDU_OP_DIVU;
`else
    localparam int MUL_STALL = 33;
    localparam logic [2:0] RST_OP = MDU_OP_MULT;
`endif
    localparam int DIV_STALL = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        stallreq, busy, hi_we, lo_we;
    logic [31:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;
    logic [65:0] exp_q[$];
    logic [65:0] mon_e;

    always #5 clk = ~clk;

    mdu_ctrl #(.DW(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .stallreq (stallreq),
        .busy     (busy),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    task automatic chk(input string name, input logic [65:0] act,
                       input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hi_we || lo_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %h expected none",
                         {hi_we, lo_we, hi_o, lo_o});
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe", {hi_we, lo_we, hi_o, lo_o}, mon_e);
            end
        end
    end

    // Issue one mul/div, hold start through DONE like EX does, then check
    // stall length and that the held start did not relaunch.
    task automatic run(input string name, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input int estall);
        int n;
        n = 0;
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        exp_q.push_back({2'b11, eh, el});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stallreq) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk({name, "_stall"}, 66'(n), 66'(estall));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_busy_after"}, 66'(busy), 66'(0));
    endtask

    task automatic move(input string name, input logic [2:0] o,
                        input logic [31:0] a, input logic [65:0] e);
        op = o;
        src_a = a;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        chk({name, "_stall"}, 66'({stallreq, busy}), 66'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        start = 1'b1;
        op = MDU_OP_MULT;
        src_a = 32'd5;
        src_b = 32'd3;
        #2;
        chk("reset_outputs",
            66'({stallreq, busy, hi_we, lo_we, hi_o, lo_o}), 66'(0));
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("divu_100_7", MDU_OP_DIVU, 32'd100, 32'd7,
            32'd2, 32'd14, DIV_STALL);
        run("div_m7_2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_STALL);
        run("div_7_m2", MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE,
            32'd1, 32'hFFFF_FFFD, DIV_STALL);
        run("div_min_m1", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000, DIV_STALL);
        run("mult_m1_2", MDU_OP_MULT, 32'hFFFF_FFFF, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL);
        run("multu_m1_2", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2,
            32'd1, 32'hFFFF_FFFE, MUL_STALL);
        run("mult_3_m5", MDU_OP_MULT, 32'd3, 32'hFFFF_FFFB,
            32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_STALL);
        run("mult_min_min", MDU_OP_MULT, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32'h0, MUL_STALL);
        run("divu_by0", MDU_OP_DIVU, 32'h1234, 32'h0,
            32'h1234, 32'hFFFF_FFFF, 1);

        move("mthi", MDU_OP_MTHI, 32'hABCD, {2'b10, 32'hABCD, 32'h0});
        move("mtlo", MDU_OP_MTLO, 32'h1234, {2'b01, 32'h0, 32'h1234});

        op = 3'b110;
        start = 1'b1;
        @(negedge clk);
        chk("undef_op", 66'({stallreq, busy}), 66'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("undef_op_busy", 66'(busy), 66'(0));

        op = MDU_OP_DIV;
        src_a = 32'd1000;
        src_b = 32'd3;
        start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_outputs", 66'({stallreq, hi_we, lo_we}), 66'(0));
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("flush_idle", 66'(busy), 66'(0));
        run("divu_after_flush", MDU_OP_DIVU, 32'd100, 32'd7,
            32'd2, 32'd14, DIV_STALL);

        op = RST_OP;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            66'({stallreq, busy, hi_we, lo_we, hi_o, lo_o}), 66'(0));
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_idle", 66'(busy), 66'(0));

        repeat (40) @(posedge clk);
        chk("queue_empty", 66'(exp_q.size()), 66'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer in the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs iterative shift-add or shift-subtract, and holds the pipeline via stall request while busy. It produces one write-enable/data pulse per HI/LO port; these feed the EX-to-ID HI/LO forwarding bus and the HI/LO register write port.

Parameters:
DW, 32, operand width. HI/LO width equals DW.
CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > DW).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
flush  in  1  exception/cancel; aborts any operation
start  in  1  EX holds a multiply/divide-class instruction
op  in  3  encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-ops
src_a  in  DW  rs operand (dividend, multiplicand, or MTHI/MTLO data)
src_b  in  DW  rt operand (divisor, multiplier)
stallreq  out  1  request from EX to hold IF/ID/EX
busy  out  1  FSM not in IDLE
hi_we  out  1  HI write strobe
lo_we  out  1  LO write strobe
hi_o  out  DW  HI write data
lo_o  out  DW  LO write data

Behaviour:
- Reset (async): state IDLE, counter 0, all datapath registers 0. All outputs 0.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE:
  - start with op MTHI: combinational hi_we=1, hi_o=src_a. No stall, state unchanged.
  - start with op MTLO: combinational lo_we=1, lo_o=src_a. No stall, state unchanged.
  - start with op MULT/MULTU: stallreq=1 combinationally. Latch abs/raw operands and sign flags; go to MUL_RUN.
  - start with op DIV/DIVU: stallreq=1 combinationally. Latch operands; go to DIV_RUN.
  - Undefined op: no action.
- MUL_RUN: 64-bit shift-add, one multiplier bit per cycle, DW cycles (counter 0..DW-1), then DONE. stallreq=1.
- DIV_RUN: restoring division on a 2*DW remainder/quotient register, one quotient bit per cycle, DW cycles, then DONE. stallreq=1.
- DONE (one cycle):
  - stallreq=0, hi_we=lo_we=1.
  - Multiply: hi_o/lo_o = upper/lower product.
  - Divide: lo_o = quotient, hi_o = remainder.
  - Next state IDLE. start is ignored in DONE, because the same EX instruction is still present; it retires at the end of this cycle.
- Latency: mul/div start cycle, then DW run cycles, then DONE. Result strobes are DW+1 cycles after start; the EX stall lasts DW+1 cycles.
- Signed ops:
  - Operate on magnitudes.
  - Product negated if src_a[DW-1]^src_b[DW-1].
  - Quotient negated if sign bits differ; remainder takes the sign of src_a.
- Unsigned ops: no sign correction.
- Boundary cases:
  - Divide by zero (DIV/DIVU, src_b=0): no iterations. Go directly to DONE next cycle with lo_o=all-ones and hi_o=src_a.
  - -2^31 / -1 signed: lo_o=0x80000000, hi_o=0.
  - -2^31 * -2^31: {hi,lo}=0x40000000_00000000.
- flush in any state: next state IDLE, counter cleared, and hi_we/lo_we forced 0 that cycle, including DONE and MTHI/MTLO. stallreq is forced 0 while flush is high.
- rst mid-operation: immediate return to IDLE with no writes.
- Outside write cycles, hi_o/lo_o are 0.

Optional Feature:
MDU_FAST_MUL_EN:
- Defined: MULT/MULTU use a single-cycle combinational DW×DW product. IDLE goes directly to DONE, giving a 1-cycle stall and strobes in the following cycle. MUL_RUN is unused.
- Undefined: iterative MUL_RUN path as above.
- Divide behaviour is identical in both builds.

Decomposition:
- Add to defines.vh: op encodings (MDU_OP_MULT..MDU_OP_MTLO), state encodings, MDU_BUS_WD=66 for the {hi_we,lo_we,hi,lo} forwarding bus.
- One sub-module, mdu_div_core: iterative restoring divider datapath with load/step/done.
- The FSM, sign handling and multiply stay in mdu_ctrl.

Test Plan:
- DIVU src_a=100, src_b=7 → stallreq high 33 cycles; DONE strobe with lo_o=14, hi_o=2; busy low next cycle.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- MULT 0xFFFFFFFF×0x00000002 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE; MULTU same operands → hi_o=1, lo_o=0xFFFFFFFE. Repeat with MDU_FAST_MUL_EN: 1-cycle stall, same results.
- DIVU src_b=0, src_a=0x1234 → DONE next cycle, lo_o=0xFFFFFFFF, hi_o=0x1234; MTHI 0xABCD in IDLE → same-cycle hi_we=1, hi_o=0xABCD, stallreq=0.
- DIV started, flush asserted on run cycle 10 → state IDLE next cycle, no hi_we/lo_we ever asserted; new DIVU afterwards completes normally.
- rst pulsed asynchronously mid-MUL_RUN (between clock edges) → outputs 0 immediately, busy=0; start held high in DONE does not relaunch an operation.
